// File: rtl/idex_stage_pkg.sv
// Shared CPU package: datapath widths, ID/EX bundle and FSM encoding.
// Writeback bypass helper is only referenced when IDEX_WB_BYPASS_EN is defined.
package idex_stage_pkg;

  localparam int REG_AW = 4;
  localparam int DATA_W = 16;
  localparam int OPC_W  = 4;
  localparam int IMM_W  = 8;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } idex_fsm_t;

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_rd;
    logic [REG_AW-1:0] sr1;
    logic [REG_AW-1:0] sr2;
    logic [REG_AW-1:0] dest;
    logic [OPC_W-1:0]  opcode;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
  } idex_bus_t;

  function automatic logic [DATA_W-1:0] wb_pick(
    input logic              en,
    input logic [REG_AW-1:0] wdest,
    input logic [REG_AW-1:0] src,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] rdata
  );
    return (en && wdest != '0 && wdest == src) ? wdata : rdata;
  endfunction

endpackage

// File: rtl/idex_stage_hazard_detect.sv
// RAW hazard between the instruction in ID and the producer held in EX.
// A match on r0 never stalls since r0 is hardwired zero.
module hazard_detect #(
  parameter int REG_AW = 4
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_sr1,
  input  logic [REG_AW-1:0] id_sr2,
  input  logic              id_use_sr1,
  input  logic              id_use_sr2,
  input  logic              ex_valid,
  input  logic              ex_wb_en,
  input  logic [REG_AW-1:0] ex_dest,
  output logic              haz
);

  logic m1;
  logic m2;

  assign m1  = id_use_sr1 && (id_sr1 == ex_dest);
  assign m2  = id_use_sr2 && (id_sr2 == ex_dest);
  assign haz = id_valid && ex_valid && ex_wb_en
            && (ex_dest != '0) && (m1 || m2);

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with RAW bubble insertion, flush and stall counter.
// Define IDEX_WB_BYPASS_EN to take operands from writeback on capture/stall.
module idex_stage
  import idex_stage_pkg::*;
#(
  parameter int REG_AW = idex_stage_pkg::REG_AW,
  parameter int DATA_W = idex_stage_pkg::DATA_W,
  parameter int OPC_W  = idex_stage_pkg::OPC_W,
  parameter int IMM_W  = idex_stage_pkg::IMM_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_sr1,
  input  logic [REG_AW-1:0] id_sr2,
  input  logic              id_use_sr1,
  input  logic              id_use_sr2,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_rd,
  input  logic [OPC_W-1:0]  id_opcode,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic              wb_en,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_stall,
  input  logic              perf_clr,
  output logic              id_stall,
  output logic              ex_valid,
  output logic              ex_wb_en,
  output logic              ex_mem_rd,
  output logic [REG_AW-1:0] ex_sr1,
  output logic [REG_AW-1:0] ex_sr2,
  output logic [REG_AW-1:0] ex_dest,
  output logic [OPC_W-1:0]  ex_opcode,
  output logic [IMM_W-1:0]  ex_imm,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic             haz;
  idex_fsm_t        state_q;
  idex_fsm_t        state_d;
  idex_bus_t        ex_q;
  idex_bus_t        ex_d;
  idex_bus_t        cap;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  hazard_detect #(.REG_AW(REG_AW)) u_haz (
    .id_valid   (id_valid),
    .id_sr1     (id_sr1),
    .id_sr2     (id_sr2),
    .id_use_sr1 (id_use_sr1),
    .id_use_sr2 (id_use_sr2),
    .ex_valid   (ex_q.valid),
    .ex_wb_en   (ex_q.wb_en),
    .ex_dest    (ex_q.dest),
    .haz        (haz)
  );

  assign id_stall = !rst && !flush && (ex_stall || haz);

  always_comb begin
    cap.valid  = id_valid;
    cap.wb_en  = id_valid && id_wb_en;
    cap.mem_rd = id_valid && id_mem_rd;
    cap.sr1    = id_sr1;
    cap.sr2    = id_sr2;
    cap.dest   = id_dest;
    cap.opcode = id_opcode;
    cap.imm    = id_imm;
`ifdef IDEX_WB_BYPASS_EN
    cap.rd1    = wb_pick(wb_en, wb_dest, id_sr1, wb_data, id_rd1);
    cap.rd2    = wb_pick(wb_en, wb_dest, id_sr2, wb_data, id_rd2);
`else
    cap.rd1    = id_rd1;
    cap.rd2    = id_rd2;
`endif
  end

`ifndef IDEX_WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_dest, wb_data};
`endif

  always_comb begin
    ex_d    = ex_q;
    state_d = state_q;
    if (flush) begin
      ex_d.valid  = 1'b0;
      ex_d.wb_en  = 1'b0;
      ex_d.mem_rd = 1'b0;
      state_d     = RUN;
    end else if (ex_stall) begin
`ifdef IDEX_WB_BYPASS_EN
      // producer may leave WB while EX waits; keep operands current
      ex_d.rd1 = wb_pick(wb_en, wb_dest, ex_q.sr1, wb_data, ex_q.rd1);
      ex_d.rd2 = wb_pick(wb_en, wb_dest, ex_q.sr2, wb_data, ex_q.rd2);
`endif
    end else if (haz) begin
      ex_d.valid  = 1'b0;
      ex_d.wb_en  = 1'b0;
      ex_d.mem_rd = 1'b0;
      state_d     = BUBBLE;
    end else begin
      ex_d    = cap;
      state_d = RUN;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (perf_clr)
      cnt_d = '0;
    else if (haz && !flush && !ex_stall && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid  = ex_q.valid;
  assign ex_wb_en  = ex_q.wb_en;
  assign ex_mem_rd = ex_q.mem_rd;
  assign ex_sr1    = ex_q.sr1;
  assign ex_sr2    = ex_q.sr2;
  assign ex_dest   = ex_q.dest;
  assign ex_opcode = ex_q.opcode;
  assign ex_imm    = ex_q.imm;
  assign ex_rd1    = ex_q.rd1;
  assign ex_rd2    = ex_q.rd2;
  assign stall_cnt = cnt_q;

endmodule
